// File: rtl/esm_config_parser.sv
// esm_config_parser: receive side of the ESM control-message protocol.
// Checks the magic / sequence / header preamble of each framed message on the
// config stream. Each payload word is forwarded to the per-module consumers,
// tagged with the module id and message type from the header.
// Optional build macro: ESM_CONFIG_PARSER_MODULE_FILTER_EN adds Module_id_filter.
// When that macro is set, only matching module ids are forwarded. 0xFF matches every id.
module esm_config_parser #(
  parameter int                        AXI_DATA_WIDTH    = 32,
  parameter logic [AXI_DATA_WIDTH-1:0] MAGIC_NUM         = 32'hE5C0_A11C,
  parameter int                        MAX_PAYLOAD_WORDS = 64
) (
  input  logic                      S_axis_clk,
  input  logic                      S_axis_resetn,
`ifdef ESM_CONFIG_PARSER_MODULE_FILTER_EN
  input  logic [7:0]                Module_id_filter,
`endif
  input  logic                      S_axis_valid,
  output logic                      S_axis_ready,
  input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic                      S_axis_last,
  output logic                      Cfg_valid,
  output logic                      Cfg_first,
  output logic                      Cfg_last,
  output logic [7:0]                Cfg_module_id,
  output logic [7:0]                Cfg_message_type,
  output logic [AXI_DATA_WIDTH-1:0] Cfg_data,
  output logic                      Err_magic,
  output logic                      Err_short,
  output logic                      Err_long,
  output logic                      Err_seq,
  output logic [AXI_DATA_WIDTH-1:0] Last_seq_num,
  output logic [15:0]               Msg_count_ok,
  output logic [15:0]               Msg_count_err
);

  localparam int CW = $clog2(MAX_PAYLOAD_WORDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PAYLOAD_WORDS - 1);

  typedef enum logic [2:0] {
    S_MAGIC,
    S_SEQ,
    S_HEADER,
    S_PAYLOAD,
    S_DRAIN
  } state_t;

  state_t                    state_q;
  logic                      ready_q;
  logic                      seqTrack_q;
  logic                      msgErr_q;
  logic [CW-1:0]             wordCnt_q;
  logic                      cfgValid_q;
  logic                      cfgFirst_q;
  logic                      cfgLast_q;
  logic [7:0]                cfgModId_q;
  logic [7:0]                cfgMsgType_q;
  logic [AXI_DATA_WIDTH-1:0] cfgData_q;
  logic                      errMagic_q;
  logic                      errShort_q;
  logic                      errLong_q;
  logic                      errSeq_q;
  logic [AXI_DATA_WIDTH-1:0] lastSeq_q;
  logic [15:0]               countOk_q;
  logic [15:0]               countErr_q;

  logic accept;
  logic seqGap;
  logic filterMatch;

  assign accept = S_axis_valid && ready_q;
  // Consecutive messages must carry consecutive sequence numbers.
  // The 32-bit add wraps, so 0xFFFFFFFF is correctly followed by 0.
  assign seqGap = seqTrack_q && (S_axis_data != (lastSeq_q + AXI_DATA_WIDTH'(1)));

`ifdef ESM_CONFIG_PARSER_MODULE_FILTER_EN
  assign filterMatch = (Module_id_filter == 8'hFF) || (S_axis_data[31:24] == Module_id_filter);
`else
  assign filterMatch = 1'b1;
`endif

  // Saturating increment for the message counters.
  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Message framing FSM. All outputs are registered: pulses last one cycle, and data/tags hold their value.
  always_ff @(posedge S_axis_clk) begin
    if (!S_axis_resetn) begin
      state_q      <= S_MAGIC;
      ready_q      <= 1'b0;
      seqTrack_q   <= 1'b0;
      msgErr_q     <= 1'b0;
      wordCnt_q    <= '0;
      cfgValid_q   <= 1'b0;
      cfgFirst_q   <= 1'b0;
      cfgLast_q    <= 1'b0;
      cfgModId_q   <= '0;
      cfgMsgType_q <= '0;
      cfgData_q    <= '0;
      errMagic_q   <= 1'b0;
      errShort_q   <= 1'b0;
      errLong_q    <= 1'b0;
      errSeq_q     <= 1'b0;
      lastSeq_q    <= '0;
      countOk_q    <= '0;
      countErr_q   <= '0;
    end else begin
      ready_q    <= 1'b1;
      cfgValid_q <= 1'b0;
      cfgFirst_q <= 1'b0;
      cfgLast_q  <= 1'b0;
      errMagic_q <= 1'b0;
      errShort_q <= 1'b0;
      errLong_q  <= 1'b0;
      errSeq_q   <= 1'b0;
      if (accept) begin
        case (state_q)
          S_MAGIC: begin
            if (S_axis_data != MAGIC_NUM) begin
              errMagic_q <= 1'b1;
              countErr_q <= satInc(countErr_q);
              if (!S_axis_last) state_q <= S_DRAIN;
            end else if (S_axis_last) begin
              errShort_q <= 1'b1;
              countErr_q <= satInc(countErr_q);
            end else begin
              state_q <= S_SEQ;
            end
          end
          S_SEQ: begin
            lastSeq_q  <= S_axis_data;
            seqTrack_q <= 1'b1;
            errSeq_q   <= seqGap;
            if (S_axis_last) begin
              errShort_q <= 1'b1;
              countErr_q <= satInc(countErr_q);
              state_q    <= S_MAGIC;
            end else begin
              msgErr_q <= seqGap;
              state_q  <= S_HEADER;
            end
          end
          S_HEADER: begin
            if (filterMatch) begin
              cfgModId_q   <= S_axis_data[31:24];
              cfgMsgType_q <= S_axis_data[23:16];
            end
            if (S_axis_last) begin
              errShort_q <= 1'b1;
              countErr_q <= satInc(countErr_q);
              state_q    <= S_MAGIC;
            end else begin
              wordCnt_q <= '0;
              state_q   <= filterMatch ? S_PAYLOAD : S_DRAIN;
            end
          end
          S_PAYLOAD: begin
            cfgValid_q <= 1'b1;
            cfgFirst_q <= (wordCnt_q == '0);
            cfgData_q  <= S_axis_data;
            wordCnt_q  <= wordCnt_q + CW'(1);
            if (S_axis_last) begin
              cfgLast_q <= 1'b1;
              if (msgErr_q) countErr_q <= satInc(countErr_q);
              else          countOk_q  <= satInc(countOk_q);
              state_q <= S_MAGIC;
            end else if (wordCnt_q == CNT_LAST) begin
              cfgLast_q  <= 1'b1;
              errLong_q  <= 1'b1;
              countErr_q <= satInc(countErr_q);
              state_q    <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (S_axis_last) state_q <= S_MAGIC;
          end
          default: state_q <= S_MAGIC;
        endcase
      end
    end
  end

  assign S_axis_ready     = ready_q;
  assign Cfg_valid        = cfgValid_q;
  assign Cfg_first        = cfgFirst_q;
  assign Cfg_last         = cfgLast_q;
  assign Cfg_module_id    = cfgModId_q;
  assign Cfg_message_type = cfgMsgType_q;
  assign Cfg_data         = cfgData_q;
  assign Err_magic        = errMagic_q;
  assign Err_short        = errShort_q;
  assign Err_long         = errLong_q;
  assign Err_seq          = errSeq_q;
  assign Last_seq_num     = lastSeq_q;
  assign Msg_count_ok     = countOk_q;
  assign Msg_count_err    = countErr_q;

endmodule

// File: tb/tb_esm_config_parser.sv
// Scoreboard bench for esm_config_parser using directed message vectors.
module tb_esm_config_parser;

  localparam logic [31:0] MAGIC = 32'hE5C0_A11C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sValid = 1'b0;
  logic        sReady;
  logic [31:0] sData = '0;
  logic        sLast = 1'b0;
  logic        cfgValid, cfgFirst, cfgLast;
  logic [7:0]  cfgModId, cfgMsgType;
  logic [31:0] cfgData;
  logic        errMagic, errShort, errLong, errSeq;
  logic [31:0] lastSeqNum;
  logic [15:0] countOk, countErr;

  int checks = 0;
  int errors = 0;
  bit gapEn = 1'b0;

  typedef struct {
    logic       v, f, l;
    logic [7:0] id, ty;
    logic [31:0] d;
    logic       em, es, el, eq;
  } ev_t;

  ev_t expQ[$];

  esm_config_parser #(.MAGIC_NUM(MAGIC)) dut (
    .S_axis_clk       (clk),
    .S_axis_resetn    (resetn),
    .S_axis_valid     (sValid),
    .S_axis_ready     (sReady),
    .S_axis_data      (sData),
    .S_axis_last      (sLast),
    .Cfg_valid        (cfgValid),
    .Cfg_first        (cfgFirst),
    .Cfg_last         (cfgLast),
    .Cfg_module_id    (cfgModId),
    .Cfg_message_type (cfgMsgType),
    .Cfg_data         (cfgData),
    .Err_magic        (errMagic),
    .Err_short        (errShort),
    .Err_long         (errLong),
    .Err_seq          (errSeq),
    .Last_seq_num     (lastSeqNum),
    .Msg_count_ok     (countOk),
    .Msg_count_err    (countErr)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void pushCfg(input bit f, input bit l, input logic [7:0] id,
                                  input logic [7:0] ty, input logic [31:0] d, input bit el);
    ev_t e;
    e.v = 1'b1; e.f = f; e.l = l; e.id = id; e.ty = ty; e.d = d;
    e.em = 1'b0; e.es = 1'b0; e.el = el; e.eq = 1'b0;
    expQ.push_back(e);
  endfunction

  function automatic void pushErr(input bit em, input bit es, input bit eq);
    ev_t e;
    e.v = 1'b0; e.f = 1'b0; e.l = 1'b0; e.id = '0; e.ty = '0; e.d = '0;
    e.em = em; e.es = es; e.el = 1'b0; e.eq = eq;
    expQ.push_back(e);
  endfunction

  // Drive one word. Idle cycles are inserted at random while gapEn is set.
  task automatic applyStimulus(input logic [31:0] w, input bit l);
    int guard;
    guard = 0;
    while (sReady !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sReady !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout actual=%b required=1", sReady);
    end
    while (gapEn && $urandom_range(0, 4) == 0) begin
      sValid = 1'b0;
      @(posedge clk);
      #1;
    end
    sValid = 1'b1;
    sData  = w;
    sLast  = l;
    @(posedge clk);
    #1;
    sValid = 1'b0;
    sLast  = 1'b0;
  endtask

  task automatic sendMsg(input logic [31:0] seq, input logic [31:0] hdr,
                         input int n, input logic [31:0] base);
    applyStimulus(MAGIC, 1'b0);
    applyStimulus(seq, 1'b0);
    applyStimulus(hdr, n == 0);
    for (int i = 0; i < n; i++) applyStimulus(base + 32'(i), i == n - 1);
  endtask

  // Monitor: whenever the DUT presents a pulse, pop the next expected event and compare it.
  initial begin : monitor
    ev_t e;
    logic [6:0] actFlags, expFlags;
    bit ok;
    forever begin
      @(negedge clk);
      if ((cfgValid | errMagic | errShort | errLong | errSeq) === 1'b1) begin
        actFlags = {cfgValid, cfgFirst, cfgLast, errMagic, errShort, errLong, errSeq};
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpectedOutput flags=%b data=%h required=no output", actFlags, cfgData);
        end else begin
          e = expQ.pop_front();
          expFlags = {e.v, e.f, e.l, e.em, e.es, e.el, e.eq};
          ok = (actFlags === expFlags) &&
               (!e.v || (cfgModId === e.id && cfgMsgType === e.ty && cfgData === e.d));
          if (!ok) begin
            errors++;
            $display("[TB] FAIL scoreboard flags=%b id=%h ty=%h data=%h required flags=%b id=%h ty=%h data=%h",
                     actFlags, cfgModId, cfgMsgType, cfgData, expFlags, e.id, e.ty, e.d);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset: every output and ready must read 0.
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReady", {31'b0, sReady}, 32'd0);
    checkOutput("resetOutputsZero",
                {31'b0, |{cfgValid, cfgFirst, cfgLast, cfgModId, cfgMsgType, cfgData, errMagic,
                          errShort, errLong, errSeq, lastSeqNum, countOk, countErr}}, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("readyAfterReset", {31'b0, sReady}, 32'd1);

    // Basic three-word payload.
    pushCfg(1, 0, 8'h01, 8'h02, 32'hA, 0);
    pushCfg(0, 0, 8'h01, 8'h02, 32'hB, 0);
    pushCfg(0, 1, 8'h01, 8'h02, 32'hC, 0);
    sendMsg(32'd0, 32'h0102_0000, 3, 32'hA);
    checkOutput("okCountBasic", {16'b0, countOk}, 32'd1);

    // Same message with idle gaps on the stream.
    gapEn = 1'b1;
    pushCfg(1, 0, 8'h01, 8'h02, 32'hA, 0);
    pushCfg(0, 0, 8'h01, 8'h02, 32'hB, 0);
    pushCfg(0, 1, 8'h01, 8'h02, 32'hC, 0);
    sendMsg(32'd1, 32'h0102_0000, 3, 32'hA);
    gapEn = 1'b0;
    checkOutput("okCountGaps", {16'b0, countOk}, 32'd2);
    checkOutput("errCountGaps", {16'b0, countErr}, 32'd0);

    // Bad magic in a five-word message, then a good message.
    pushErr(1, 0, 0);
    applyStimulus(32'h1234_5678, 1'b0);
    applyStimulus(32'h1, 1'b0);
    applyStimulus(32'h2, 1'b0);
    applyStimulus(32'h3, 1'b0);
    applyStimulus(32'h4, 1'b1);
    pushCfg(1, 1, 8'h03, 8'h04, 32'h11, 0);
    sendMsg(32'd2, 32'h0304_0000, 1, 32'h11);
    checkOutput("errCountMagic", {16'b0, countErr}, 32'd1);
    checkOutput("okCountMagic", {16'b0, countOk}, 32'd3);

    // Sequence wrap: 2 -> FFFFFFFF is a gap, FFFFFFFF -> 0 is not, 0 -> 5 is.
    pushErr(0, 0, 1);
    pushCfg(1, 1, 8'h05, 8'h06, 32'h21, 0);
    sendMsg(32'hFFFF_FFFF, 32'h0506_0000, 1, 32'h21);
    pushCfg(1, 1, 8'h05, 8'h06, 32'h22, 0);
    sendMsg(32'd0, 32'h0506_0000, 1, 32'h22);
    pushErr(0, 0, 1);
    pushCfg(1, 1, 8'h05, 8'h06, 32'h23, 0);
    sendMsg(32'd5, 32'h0506_0000, 1, 32'h23);
    checkOutput("lastSeqAfterGap", lastSeqNum, 32'd5);
    checkOutput("errCountSeq", {16'b0, countErr}, 32'd3);
    checkOutput("okCountSeq", {16'b0, countOk}, 32'd4);

    // Header-only message, then an over-length payload, then a normal message.
    pushErr(0, 1, 0);
    sendMsg(32'd6, 32'h0708_0000, 0, 32'h0);
    for (int i = 0; i < 64; i++)
      pushCfg(i == 0, i == 63, 8'h0A, 8'h0B, 32'h100 + 32'(i), i == 63);
    sendMsg(32'd7, 32'h0A0B_0000, 70, 32'h100);
    pushCfg(1, 1, 8'h0C, 8'h0D, 32'h55, 0);
    sendMsg(32'd8, 32'h0C0D_0000, 1, 32'h55);
    checkOutput("errCountShortLong", {16'b0, countErr}, 32'd5);
    checkOutput("okCountAfterLong", {16'b0, countOk}, 32'd5);
    checkOutput("lastSeqAfterLong", lastSeqNum, 32'd8);

    // Reset after the second payload word abandons the message.
    pushCfg(1, 0, 8'h0E, 8'h0F, 32'h61, 0);
    pushCfg(0, 0, 8'h0E, 8'h0F, 32'h62, 0);
    applyStimulus(MAGIC, 1'b0);
    applyStimulus(32'd9, 1'b0);
    applyStimulus(32'h0E0F_0000, 1'b0);
    applyStimulus(32'h61, 1'b0);
    applyStimulus(32'h62, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midResetReady", {31'b0, sReady}, 32'd0);
    checkOutput("midResetOutputsZero",
                {31'b0, |{cfgValid, cfgFirst, cfgLast, cfgModId, cfgMsgType, cfgData, errMagic,
                          errShort, errLong, errSeq, lastSeqNum, countOk, countErr}}, 32'd0);
    resetn = 1'b1;
    pushCfg(1, 0, 8'h01, 8'h02, 32'h71, 0);
    pushCfg(0, 1, 8'h01, 8'h02, 32'h72, 0);
    sendMsg(32'd100, 32'h0102_0000, 2, 32'h71);
    checkOutput("okCountPostReset", {16'b0, countOk}, 32'd1);
    checkOutput("errCountPostReset", {16'b0, countErr}, 32'd0);
    checkOutput("lastSeqPostReset", lastSeqNum, 32'd100);

    repeat (5) @(posedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
